// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter in front of a single-port data BRAM
//
// Purpose:
//   Shares one single-port BRAM between the CPU requester (read/write) and the
//   inference readout requester (read-only). One access is outstanding at a time,
//   sequenced by an IDLE -> ISSUE -> (WAIT -> RET) -> IDLE state machine. Every
//   output is a flop.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i    CPU request; held until cpu_gnt_o
//   cpu_gnt_o, cpu_rvalid_o          single-cycle grant / read-return pulses
//   cpu_rdata_o                      last CPU read data (held)
//   inf_req_i/addr_i                 inference read request; held until inf_gnt_o
//   inf_gnt_o, inf_rvalid_o          single-cycle grant / read-return pulses
//   inf_rdata_o                      last inference read data (held)
//   mem_en_o/we_o/addr_o/wdata_o     BRAM control, valid only in ISSUE
//   mem_rdata_i                      BRAM read data, RD_LAT cycles after mem_en_o
//   busy_o                           state machine is not idle
//
// Build option:
//   ARB_STARVE_GUARD_EN - after STARVE_LIMIT CPU grants with inf_req_i pending,
//   the inference requester wins the next contended arbitration. Without it the
//   CPU has strict priority.

module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              inf_req_i,
    input  logic [ADDR_W-1:0] inf_addr_i,
    output logic              inf_gnt_o,
    output logic              inf_rvalid_o,
    output logic [DATA_W-1:0] inf_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RET   = 2'd3;

    // WAIT counts down from RD_LAT-1 so that the capture lines up with the BRAM output.
    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    localparam bit PARAMS_OK = (RD_LAT >= 1) && (RD_LAT <= 4) && (STARVE_LIMIT >= 1);

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("mem_port_arbiter: RD_LAT must be 1..4 and STARVE_LIMIT at least 1");
        end
    endgenerate

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              win_inf_q, win_inf_d;
    logic              we_q, we_d;

    logic              cpu_gnt_q, cpu_gnt_d;
    logic              inf_gnt_q, inf_gnt_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              inf_rvalid_q, inf_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] inf_rdata_q, inf_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;

    logic              inf_wins;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;

    // Counts CPU grants taken while the inference side was waiting; any inference
    // grant, or an idle cycle with no inference request, means it is not starving.
    always_comb begin
        starve_d = starve_q;
        if (inf_gnt_q || (state_q == S_IDLE && !inf_req_i)) begin
            starve_d = '0;
        end else if (cpu_gnt_q && inf_req_i && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign inf_wins = inf_req_i && (!cpu_req_i || starve_q == STARVE_MAX);
`else
    assign inf_wins = inf_req_i && !cpu_req_i;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        win_inf_d    = win_inf_q;
        we_d         = we_q;
        cpu_gnt_d    = 1'b0;
        inf_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        inf_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        inf_rdata_d  = inf_rdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;

        case (state_q)
            S_IDLE: begin
                // The BRAM strobes are decided here so they appear, registered,
                // exactly during ISSUE.
                if (cpu_req_i || inf_req_i) begin
                    state_d   = S_ISSUE;
                    mem_en_d  = 1'b1;
                    win_inf_d = inf_wins;
                    if (inf_wins) begin
                        inf_gnt_d  = 1'b1;
                        we_d       = 1'b0;
                        mem_addr_d = inf_addr_i;
                    end else begin
                        cpu_gnt_d   = 1'b1;
                        we_d        = cpu_we_i;
                        mem_we_d    = cpu_we_i;
                        mem_addr_d  = cpu_addr_i;
                        mem_wdata_d = cpu_wdata_i;
                    end
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = LAT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_RET;
                    if (win_inf_q) begin
                        inf_rvalid_d = 1'b1;
                        inf_rdata_d  = mem_rdata_i;
                    end else begin
                        cpu_rvalid_d = 1'b1;
                        cpu_rdata_d  = mem_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RET: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            win_inf_q    <= 1'b0;
            we_q         <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            inf_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            inf_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            inf_rdata_q  <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            win_inf_q    <= win_inf_d;
            we_q         <= we_d;
            cpu_gnt_q    <= cpu_gnt_d;
            inf_gnt_q    <= inf_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            inf_rvalid_q <= inf_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            inf_rdata_q  <= inf_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign cpu_gnt_o    = cpu_gnt_q;
    assign inf_gnt_o    = inf_gnt_q;
    assign cpu_rvalid_o = cpu_rvalid_q;
    assign inf_rvalid_o = inf_rvalid_q;
    assign cpu_rdata_o  = cpu_rdata_q;
    assign inf_rdata_o  = inf_rdata_q;
    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter at RD_LAT 1 and 4

module tb_mem_port_arbiter;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD      = 1'b1;
    localparam int EXP_GRANTS = 27;
`else
    localparam bit GUARD      = 1'b0;
    localparam int EXP_GRANTS = 30;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Instance A: RD_LAT = 1
    logic        a_rst, a_creq, a_cwe, a_ireq;
    logic [15:0] a_caddr, a_iaddr;
    logic [31:0] a_cwdata;
    logic        a_cpu_gnt, a_cpu_rvalid, a_inf_gnt, a_inf_rvalid;
    logic [31:0] a_cpu_rdata, a_inf_rdata;
    logic        a_mem_en, a_mem_we, a_busy;
    logic [15:0] a_mem_addr;
    logic [31:0] a_mem_wdata, a_mem_rdata;
    logic [31:0] mem_a [0:255];

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1), .STARVE_LIMIT(8)) u_dut_a (
        .clk_i(clk), .rst_i(a_rst),
        .cpu_req_i(a_creq), .cpu_we_i(a_cwe), .cpu_addr_i(a_caddr), .cpu_wdata_i(a_cwdata),
        .cpu_gnt_o(a_cpu_gnt), .cpu_rvalid_o(a_cpu_rvalid), .cpu_rdata_o(a_cpu_rdata),
        .inf_req_i(a_ireq), .inf_addr_i(a_iaddr),
        .inf_gnt_o(a_inf_gnt), .inf_rvalid_o(a_inf_rvalid), .inf_rdata_o(a_inf_rdata),
        .mem_en_o(a_mem_en), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
        .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata), .busy_o(a_busy)
    );

    always @(posedge clk) begin
        if (a_mem_en) begin
            if (a_mem_we) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
            else          a_mem_rdata <= mem_a[a_mem_addr[7:0]];
        end
    end

    // Instance B: RD_LAT = 4
    logic        b_rst, b_creq, b_cwe, b_ireq;
    logic [15:0] b_caddr, b_iaddr;
    logic [31:0] b_cwdata;
    logic        b_cpu_gnt, b_cpu_rvalid, b_inf_gnt, b_inf_rvalid;
    logic [31:0] b_cpu_rdata, b_inf_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [15:0] b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [31:0] mem_b [0:255];
    logic [31:0] b_pipe [0:3];

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(4), .STARVE_LIMIT(8)) u_dut_b (
        .clk_i(clk), .rst_i(b_rst),
        .cpu_req_i(b_creq), .cpu_we_i(b_cwe), .cpu_addr_i(b_caddr), .cpu_wdata_i(b_cwdata),
        .cpu_gnt_o(b_cpu_gnt), .cpu_rvalid_o(b_cpu_rvalid), .cpu_rdata_o(b_cpu_rdata),
        .inf_req_i(b_ireq), .inf_addr_i(b_iaddr),
        .inf_gnt_o(b_inf_gnt), .inf_rvalid_o(b_inf_rvalid), .inf_rdata_o(b_inf_rdata),
        .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_pipe[3]), .busy_o(b_busy)
    );

    always @(posedge clk) begin
        if (b_mem_en && b_mem_we) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
        b_pipe[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr[7:0]] : 32'h0;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
        b_pipe[3] <= b_pipe[2];
    end

    // in_bits = {rst, cpu_req, cpu_we, inf_req}
    // exp_bits = {cpu_gnt, cpu_rvalid, inf_gnt, inf_rvalid, mem_en, mem_we, busy}
    typedef struct {
        logic [3:0]  in_bits;
        logic [15:0] caddr;
        logic [31:0] cwdata;
        logic [15:0] iaddr;
        logic [6:0]  exp_bits;
        logic [15:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] crd;
        logic [31:0] ird;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [3:0] ib, input logic [15:0] ca, input logic [31:0] cw,
                                input logic [15:0] ia, input logic [6:0] eb, input logic [15:0] ma,
                                input logic [31:0] mw, input logic [31:0] crd, input logic [31:0] ird);
        vec_t v;
        v.in_bits = ib; v.caddr = ca; v.cwdata = cw; v.iaddr = ia;
        v.exp_bits = eb; v.maddr = ma; v.mwdata = mw; v.crd = crd; v.ird = ird;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic b_write(input logic [15:0] a, input logic [31:0] d);
        b_creq = 1'b1; b_cwe = 1'b1; b_caddr = a; b_cwdata = d;
        @(negedge clk);
        check("b_write_gnt", {b_cpu_gnt, b_mem_en, b_mem_we, b_mem_addr}, {3'b111, a});
        b_creq = 1'b0;
        @(negedge clk);
    endtask

    task automatic b_read(input logic [15:0] a, input logic [31:0] exp, input string tag);
        int k;
        bit got;
        b_creq = 1'b1; b_cwe = 1'b0; b_caddr = a;
        @(negedge clk);
        check({tag, "_gnt"}, {b_cpu_gnt, b_mem_en, b_mem_we, b_inf_gnt}, 4'b1100);
        b_creq = 1'b0;
        k = 1; got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (b_cpu_rvalid) got = 1'b1;
        end
        check({tag, "_latency"}, k, 6);
        check({tag, "_data"}, b_cpu_rdata, exp);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] ctrl;
        bit         ok;
        bit         gq [$];
        int         both;
        int         seen;

        a_rst = 1'b1; a_creq = 1'b0; a_cwe = 1'b0; a_ireq = 1'b0;
        a_caddr = '0; a_iaddr = '0; a_cwdata = '0;
        b_rst = 1'b1; b_creq = 1'b0; b_cwe = 1'b0; b_ireq = 1'b0;
        b_caddr = '0; b_iaddr = '0; b_cwdata = '0;

        vecs[0]  = mk(4'b1101, 16'h0010, 32'hDEADBEEF, 16'h0010, 7'b0000000, 16'h0000, 32'h0,        32'h0,        32'h0);
        vecs[1]  = mk(4'b1101, 16'h0010, 32'hDEADBEEF, 16'h0010, 7'b0000000, 16'h0000, 32'h0,        32'h0,        32'h0);
        vecs[2]  = mk(4'b0111, 16'h0010, 32'hDEADBEEF, 16'h0010, 7'b1000111, 16'h0010, 32'hDEADBEEF, 32'h0,        32'h0);
        vecs[3]  = mk(4'b0000, 16'h0000, 32'h0,        16'h0000, 7'b0000000, 16'h0000, 32'h0,        32'h0,        32'h0);
        vecs[4]  = mk(4'b0100, 16'h0010, 32'h0,        16'h0000, 7'b1000101, 16'h0010, 32'h0,        32'h0,        32'h0);
        vecs[5]  = mk(4'b0000, 16'h0000, 32'h0,        16'h0000, 7'b0000001, 16'h0000, 32'h0,        32'h0,        32'h0);
        vecs[6]  = mk(4'b0000, 16'h0000, 32'h0,        16'h0000, 7'b0100001, 16'h0000, 32'h0,        32'hDEADBEEF, 32'h0);
        vecs[7]  = mk(4'b0000, 16'h0000, 32'h0,        16'h0000, 7'b0000000, 16'h0000, 32'h0,        32'hDEADBEEF, 32'h0);
        vecs[8]  = mk(4'b0001, 16'h0000, 32'h0,        16'h0010, 7'b0010101, 16'h0010, 32'h0,        32'hDEADBEEF, 32'h0);
        vecs[9]  = mk(4'b0000, 16'h0000, 32'h0,        16'h0000, 7'b0000001, 16'h0000, 32'h0,        32'hDEADBEEF, 32'h0);
        vecs[10] = mk(4'b0000, 16'h0000, 32'h0,        16'h0000, 7'b0001001, 16'h0000, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF);
        vecs[11] = mk(4'b0000, 16'h0000, 32'h0,        16'h0000, 7'b0000000, 16'h0000, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF);
        vecs[12] = mk(4'b0111, 16'h0020, 32'h12345678, 16'h0020, 7'b1000111, 16'h0020, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF);
        vecs[13] = mk(4'b0001, 16'h0000, 32'h0,        16'h0020, 7'b0000000, 16'h0000, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF);
        vecs[14] = mk(4'b0001, 16'h0000, 32'h0,        16'h0020, 7'b0010101, 16'h0020, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF);
        vecs[15] = mk(4'b0100, 16'h0020, 32'h0,        16'h0000, 7'b0000001, 16'h0000, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF);
        vecs[16] = mk(4'b0100, 16'h0020, 32'h0,        16'h0000, 7'b0001001, 16'h0000, 32'h0,        32'hDEADBEEF, 32'h12345678);
        vecs[17] = mk(4'b0100, 16'h0020, 32'h0,        16'h0000, 7'b0000000, 16'h0000, 32'h0,        32'hDEADBEEF, 32'h12345678);
        vecs[18] = mk(4'b0100, 16'h0020, 32'h0,        16'h0000, 7'b1000101, 16'h0020, 32'h0,        32'hDEADBEEF, 32'h12345678);
        vecs[19] = mk(4'b0000, 16'h0000, 32'h0,        16'h0000, 7'b0000001, 16'h0000, 32'h0,        32'hDEADBEEF, 32'h12345678);
        vecs[20] = mk(4'b0000, 16'h0000, 32'h0,        16'h0000, 7'b0100001, 16'h0000, 32'h0,        32'h12345678, 32'h12345678);
        vecs[21] = mk(4'b0000, 16'h0000, 32'h0,        16'h0000, 7'b0000000, 16'h0000, 32'h0,        32'h12345678, 32'h12345678);
        vecs[22] = mk(4'b0110, 16'h0030, 32'hA5A5A5A5, 16'h0000, 7'b1000111, 16'h0030, 32'hA5A5A5A5, 32'h12345678, 32'h12345678);
        vecs[23] = mk(4'b0110, 16'h0031, 32'h5A5A5A5A, 16'h0000, 7'b0000000, 16'h0000, 32'h0,        32'h12345678, 32'h12345678);
        vecs[24] = mk(4'b0110, 16'h0031, 32'h5A5A5A5A, 16'h0000, 7'b1000111, 16'h0031, 32'h5A5A5A5A, 32'h12345678, 32'h12345678);
        vecs[25] = mk(4'b0000, 16'h0000, 32'h0,        16'h0000, 7'b0000000, 16'h0000, 32'h0,        32'h12345678, 32'h12345678);
        vecs[26] = mk(4'b0100, 16'h0031, 32'h0,        16'h0000, 7'b1000101, 16'h0031, 32'h0,        32'h12345678, 32'h12345678);
        vecs[27] = mk(4'b0000, 16'h0000, 32'h0,        16'h0000, 7'b0000001, 16'h0000, 32'h0,        32'h12345678, 32'h12345678);
        vecs[28] = mk(4'b0000, 16'h0000, 32'h0,        16'h0000, 7'b0100001, 16'h0000, 32'h0,        32'h5A5A5A5A, 32'h12345678);
        vecs[29] = mk(4'b0000, 16'h0000, 32'h0,        16'h0000, 7'b0000000, 16'h0000, 32'h0,        32'h5A5A5A5A, 32'h12345678);

        // Instance A: cycle-by-cycle vectors; inputs set after a falling edge,
        // outputs compared at the next falling edge.
        for (int i = 0; i < NVEC; i++) begin
            {a_rst, a_creq, a_cwe, a_ireq} = vecs[i].in_bits;
            a_caddr  = vecs[i].caddr;
            a_cwdata = vecs[i].cwdata;
            a_iaddr  = vecs[i].iaddr;
            @(negedge clk);
            ctrl = {a_cpu_gnt, a_cpu_rvalid, a_inf_gnt, a_inf_rvalid, a_mem_en, a_mem_we, a_busy};
            ok = (ctrl === vecs[i].exp_bits) && (a_cpu_rdata === vecs[i].crd) && (a_inf_rdata === vecs[i].ird);
            if (vecs[i].exp_bits[2]) ok = ok && (a_mem_addr === vecs[i].maddr);
            if (vecs[i].exp_bits[2] && vecs[i].exp_bits[1]) ok = ok && (a_mem_wdata === vecs[i].mwdata);
            n_checks++;
            if (!ok) begin
                n_err++;
                $display("FAIL vec%0d: ctrl=%b/%b addr=%h/%h wdata=%h/%h cpu_rdata=%h/%h inf_rdata=%h/%h (got/expected)",
                         i, ctrl, vecs[i].exp_bits, a_mem_addr, vecs[i].maddr, a_mem_wdata, vecs[i].mwdata,
                         a_cpu_rdata, vecs[i].crd, a_inf_rdata, vecs[i].ird);
            end
        end

        // Contention: CPU writes and inference reads both held high for 60 cycles.
        a_creq = 1'b1; a_cwe = 1'b1; a_caddr = 16'h0050; a_cwdata = 32'h0000_0055;
        a_ireq = 1'b1; a_iaddr = 16'h0050;
        both = 0;
        for (int e = 1; e <= 60; e++) begin
            @(negedge clk);
            if (a_cpu_gnt && a_inf_gnt) both++;
            if (a_cpu_gnt || a_inf_gnt) gq.push_back(a_inf_gnt);
        end
        check("contention_both_gnt", both, 0);
        check("contention_grant_count", gq.size(), EXP_GRANTS);
        for (int i = 0; i < gq.size(); i++) begin
            check($sformatf("contention_grant%0d_is_inf", i), gq[i], GUARD && (i % 9 == 8));
        end
        a_creq = 1'b0; a_ireq = 1'b0;
        for (int e = 0; e < 10 && a_busy; e++) @(negedge clk);
        check("contention_drain_idle", a_busy, 0);

        // Instance B: held in reset so far; outputs must be clear.
        check("b_reset_outputs", {b_cpu_gnt, b_cpu_rvalid, b_inf_gnt, b_inf_rvalid, b_mem_en, b_mem_we, b_busy}, 0);
        b_rst = 1'b0;
        @(negedge clk);
        b_write(16'h0040, 32'hCAFEF00D);
        b_read(16'h0040, 32'hCAFEF00D, "b_read1");

        // Reset while a read sits in WAIT: the read is dropped silently.
        b_creq = 1'b1; b_cwe = 1'b0; b_caddr = 16'h0040;
        @(negedge clk);
        check("b_midread_gnt", b_cpu_gnt, 1);
        b_creq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b_midread_busy", b_busy, 1);
        #2 b_rst = 1'b1;
        #1;
        check("b_midread_reset_ctrl", {b_cpu_gnt, b_cpu_rvalid, b_inf_gnt, b_inf_rvalid, b_mem_en, b_mem_we, b_busy}, 0);
        check("b_midread_reset_rdata", b_cpu_rdata, 0);
        @(negedge clk);
        b_rst = 1'b0;
        seen = 0;
        for (int e = 0; e < 8; e++) begin
            @(negedge clk);
            if (b_cpu_rvalid || b_inf_rvalid) seen++;
        end
        check("b_midread_no_rvalid", seen, 0);
        b_write(16'h0041, 32'h0BADCAFE);
        b_read(16'h0041, 32'h0BADCAFE, "b_read2");
        b_read(16'h0040, 32'hCAFEF00D, "b_read3");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
